// File: rtl/stream_ready_throttle.sv
// stream_ready_throttle
//
// Consumer-side back-pressure injector for a valid/ready stream. The payload
// and, while the block is open, the handshake signals pass straight through.
// After every accepted beat the stream is closed for D cycles. During that
// time valid_o and ready_o are both low. D is either a fixed parameter or the
// low CounterBits of a free-running 16-bit LFSR. A saturating 16-bit counter
// records how many cycles were spent stalling.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   en_i         throttling enable (0 = pure pass-through)
//   clr_i        synchronous clear of stall_cnt_o
//   data_i       upstream payload
//   valid_i      upstream valid
//   ready_o      upstream ready
//   data_o       downstream payload (combinational copy of data_i)
//   valid_o      downstream valid
//   ready_i      downstream ready
//   stalling_o   high while in the STALL state
//   stall_cnt_o  saturating count of enabled STALL cycles
module stream_ready_throttle #(
   parameter int unsigned DataWidth   = 32,
   parameter bit          StallRandom = 1'b0,
   parameter int unsigned FixedDelay  = 1,
   parameter int unsigned CounterBits = 4,
   parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 clr_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic [DataWidth-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 stalling_o,
   output logic [15:0]          stall_cnt_o
);

   typedef enum logic {
      ST_OPEN  = 1'b0,
      ST_STALL = 1'b1
   } state_e;

   state_e                 state_q;
   logic [CounterBits-1:0] cnt_q;
   logic [CounterBits-1:0] delay_d;
   logic [15:0]            stall_cnt_q;
   logic                   open_path;
   logic                   hs_open;

   // Disabling the block must act within the same cycle, even mid-stall, so
   // the enable participates combinationally in the pass-through decision.
   assign open_path  = ~en_i | (state_q == ST_OPEN);
   assign valid_o    = open_path & valid_i;
   assign ready_o    = open_path & ready_i;
   assign data_o     = data_i;
   assign stalling_o = (state_q == ST_STALL);

   // Only a throttled handshake in OPEN starts a stall and advances the LFSR.
   assign hs_open = en_i & valid_i & ready_i & (state_q == ST_OPEN);

   if (StallRandom) begin : g_lfsr
      logic [15:0] lfsr_q;

      // Fibonacci LFSR, taps 16/14/13/11, shifting towards the MSB.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            lfsr_q <= LfsrSeed;
         end else if (hs_open) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         end
      end

      assign delay_d = lfsr_q[CounterBits-1:0];
   end else begin : g_fixed
      localparam logic [CounterBits-1:0] FixedD = CounterBits'(FixedDelay);
      assign delay_d = FixedD;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_OPEN;
         cnt_q   <= '0;
      end else if (!en_i) begin
         state_q <= ST_OPEN;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_OPEN: begin
               // A zero delay keeps the block open, so back-to-back beats pass.
               if (hs_open && (delay_d != '0)) begin
                  state_q <= ST_STALL;
                  cnt_q   <= delay_d;
               end
            end
            ST_STALL: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CounterBits'(1)) begin
                  state_q <= ST_OPEN;
               end
            end
            default: begin
               state_q <= ST_OPEN;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Clear wins over increment, so a clear issued during a stall cycle leaves 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
      end else if (clr_i) begin
         stall_cnt_q <= '0;
      end else if (stalling_o && en_i && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;

   a_seed_nonzero: assert property (@(posedge clk_i) LfsrSeed != 16'h0)
      else $error("LfsrSeed must be nonzero");
   a_fixed_range: assert property (@(posedge clk_i) (FixedDelay >> CounterBits) == 0)
      else $error("FixedDelay does not fit in CounterBits");
   a_lfsr_width: assert property (@(posedge clk_i) !StallRandom || (CounterBits <= 16))
      else $error("random stall length cannot exceed the 16-bit LFSR");
   a_no_hs_in_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(stalling_o && en_i && (valid_o || ready_o)))
      else $error("handshake signals open while stalling");

endmodule

// File: doc/stream_ready_throttle.md
Name: stream_ready_throttle

Overview:
- Consumer-side counterpart to the stream valid-delay block.
- It does not delay valid. After every accepted beat, it withholds ready/valid on the stream for a fixed or pseudo-random number of cycles.
- Sits between a stream source and a sink in testbenches and optional stress configurations, where it injects back-pressure.
- Also keeps a saturating count of the cycles it has stalled.

Parameters:
- DataWidth, 32: payload width in bits.
- StallRandom, 1'b0: 0 = fixed stall length; 1 = stall length taken from an internal LFSR.
- FixedDelay, 1: stall cycles after each handshake when StallRandom=0; range 0..2^CounterBits-1.
- CounterBits, 4: width of the stall counter; maximum random stall is 2^CounterBits-1.
- LfsrSeed, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- en_i  in  1  throttling enable; 0 = pure pass-through.
- clr_i  in  1  synchronous clear of stall_cnt_o.
- data_i  in  DataWidth  upstream payload.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- data_o  out  DataWidth  downstream payload.
- valid_o  out  1  downstream valid.
- ready_i  in  1  downstream ready.
- stalling_o  out  1  high while in the STALL state.
- stall_cnt_o  out  16  saturating count of STALL cycles.

Behaviour:
- data_o = data_i always; combinational, zero latency.
- FSM with two states, OPEN and STALL. Reset state is OPEN.
- OPEN:
  - valid_o = valid_i, ready_o = ready_i; no added latency.
  - A handshake (valid_i & ready_i & en_i) samples the delay D.
  - If D == 0, stay in OPEN.
  - Otherwise load cnt_q = D and go to STALL.
- STALL:
  - valid_o = 0, ready_o = 0, stalling_o = 1.
  - cnt_q decrements each cycle. When cnt_q == 1, next state is OPEN.
  - Result: exactly D cycles with ready_o=0 after the handshake cycle.
- D source:
  - StallRandom=0: D = FixedDelay[CounterBits-1:0].
  - StallRandom=1: D = lfsr_q[CounterBits-1:0], sampled in the handshake cycle.
- LFSR:
  - 16-bit Fibonacci; shifts left; feedback bit0 = q[15]^q[13]^q[12]^q[10].
  - Advances only on a handshake in OPEN (including D == 0 handshakes).
  - Reset value is LfsrSeed.
  - When StallRandom=0, the LFSR is not instantiated.
- en_i = 0:
  - Next state is forced to OPEN from either state; cnt_q is cleared.
  - The LFSR holds.
  - Outputs are pure pass-through in the same cycle, including while in STALL.
- en_i rising: no stall until the next handshake.
- stall_cnt_o:
  - Increments by 1 in every cycle where stalling_o = 1 and en_i = 1.
  - Saturates at 16'hFFFF.
  - clr_i has priority over increment; it clears to 0 on the next edge.
- No handshake can occur in STALL, since valid_o and ready_o are both 0. Upstream holding valid_i is legal, and its data is not consumed.
- In OPEN, valid_i held with ready_i = 0 produces no state change and no LFSR advance.
- Reset values:
  - state = OPEN, cnt_q = 0, lfsr_q = LfsrSeed, stall_cnt_o = 0, stalling_o = 0.
  - valid_o and ready_o follow the pass-through combinational inputs.
- Reset mid-STALL returns to OPEN immediately, asynchronously.
- Assertions (simulation only):
  - LfsrSeed != 0.
  - FixedDelay < 2^CounterBits.
  - No handshake while stalling_o = 1.

Test Plan:
- StallRandom=0, FixedDelay=0, en_i=1, valid_i=ready_i=1 for 10 cycles -> 10 handshakes in 10 cycles; stalling_o never 1; stall_cnt_o=0.
- FixedDelay=3, valid_i=ready_i=1 continuously -> handshakes at cycles 0,4,8,12; ready_o low in cycles 1-3, 5-7, ...; after 13 cycles stall_cnt_o=9.
- FixedDelay=3; handshake at cycle 0, then en_i=0 at cycle 2 -> cycle 2 shows pass-through and a handshake; stall_cnt_o=1; no stall follows while en_i=0.
- StallRandom=1, LfsrSeed=16'hACE1 -> first stall length = 1 (0xACE1 & 0xF); second stall length = lfsr_q[3:0] after one shift (0x59C3 -> 3); matches a reference model for 100 handshakes.
- Saturation: force the count near its limit, then stall continuously -> stall_cnt_o holds at 16'hFFFF. clr_i pulse -> 0 next cycle; clr_i together with a stall cycle -> 0, not 1.
- FixedDelay=5; assert rst_ni=0 two cycles into STALL -> immediately OPEN, stall_cnt_o=0. After release, the first handshake starts a fresh 5-cycle stall.
